// File: rtl/jtag_master_if.sv
// jtag_master_if: command/response channel plus the JTAG pins between sequencer, master and TAP
interface jtag_master_if #(
  parameter int WIDTH = 8
) ();
  localparam int LW = $clog2(WIDTH) + 1;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_rst;
  logic             cmd_ir;
  logic [LW-1:0]    cmd_len;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             tck;
  logic             tms;
  logic             tdi;
  logic             trst;
  logic             tdo;
  modport master (
    input  cmd_valid, cmd_rst, cmd_ir, cmd_len, cmd_data, tdo,
    output cmd_ready, rsp_valid, rsp_data, tck, tms, tdi, trst
  );
  modport slave (
    output cmd_valid, cmd_rst, cmd_ir, cmd_len, cmd_data, tdo,
    input  cmd_ready, rsp_valid, rsp_data, tck, tms, tdi, trst
  );
endinterface

// File: rtl/jtag_master.sv
// jtag_master: command-driven JTAG controller that walks the TAP to Shift-IR/DR,
// shifts LSB-first, returns to Run-Test/Idle and reports the captured TDO bits.
module jtag_master #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input logic           clk,
  input logic           rst,
  jtag_master_if.master bus
);
  localparam int LW = $clog2(WIDTH) + 1;
  localparam int CW = (LW > 3) ? LW : 3;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [2:0] RSTSEQ = 3'd0, IDLE = 3'd1, HEAD = 3'd2, SHIFT = 3'd3, TAIL = 3'd4;
  logic [2:0]       state, nstate;
  logic [DW-1:0]    div_cnt;
  logic [CW-1:0]    cnt, ncnt, len_m1;
  logic [LW-1:0]    len;
  logic [WIDTH-1:0] sh, sh_nx, mask, rsp_data;
  logic             tck, tms, tdi, trst, cmd_ready, rsp_valid, ir, is_cmd;
  logic             busy, tick, last, ntms, ntdi;
  // cnt indexes the TCK period within the current state; TMS/TDI for the next period are derived from it
  always_comb begin
    busy   = state != IDLE;
    tick   = div_cnt == DW'(DIV - 1);
    len_m1 = CW'(len) - CW'(1);
    last   = state == RSTSEQ ? cnt == CW'(5) :
             state == HEAD   ? cnt == (ir ? CW'(3) : CW'(2)) :
             state == SHIFT  ? cnt == len_m1 : cnt == CW'(1);
    nstate = !last ? state : state == HEAD ? SHIFT : state == SHIFT ? TAIL : IDLE;
    ncnt   = last ? '0 : cnt + CW'(1);
    sh_nx  = state == SHIFT ? sh >> 1 : sh;
    ntms   = nstate == RSTSEQ ? ncnt != CW'(5) :
             nstate == HEAD   ? (ir ? ncnt < CW'(2) : ncnt == '0) :
             nstate == SHIFT  ? ncnt == len_m1 : nstate == TAIL && ncnt == '0;
    ntdi   = nstate == SHIFT && sh_nx[0];
  end
  always_ff @(posedge clk) begin
    trst      <= rst;
    rsp_valid <= 1'b0;
    if (rst) begin
      state     <= RSTSEQ;
      div_cnt   <= '0;
      cnt       <= '0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_data  <= '0;
      is_cmd    <= 1'b0;
    end else if (!busy) begin
      if (bus.cmd_valid && cmd_ready) begin
        state     <= bus.cmd_rst ? RSTSEQ : HEAD;
        is_cmd    <= 1'b1;
        ir        <= bus.cmd_ir;
        len       <= bus.cmd_len == '0 ? LW'(WIDTH) : bus.cmd_len;
        sh        <= bus.cmd_data;
        mask      <= WIDTH'(1);
        rsp_data  <= '0;
        cnt       <= '0;
        tms       <= 1'b1;
        tdi       <= 1'b0;
        cmd_ready <= 1'b0;
      end
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) tck <= ~tck;
      // TDO is captured on the edge where TCK rises, one-hot mask marks the bit slot
      if (tick && !tck && state == SHIFT) begin
        rsp_data <= rsp_data | ({WIDTH{bus.tdo}} & mask);
        mask     <= mask << 1;
      end
      if (tick && tck) begin
        state <= nstate;
        cnt   <= ncnt;
        tms   <= ntms;
        tdi   <= ntdi;
        sh    <= sh_nx;
        if (nstate == IDLE) begin
          cmd_ready <= 1'b1;
          rsp_valid <= state != RSTSEQ || is_cmd;
        end
      end
    end
  end
  assign bus.tck       = tck;
  assign bus.tms       = tms;
  assign bus.tdi       = tdi;
  assign bus.trst      = trst;
  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: two masters (DIV=1 and DIV=2) driving behavioural TAPs; expected
// responses are queued at issue time and popped by a monitor on rsp_valid.
module tb_jtag_master;
  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6, EX2DR = 7, UPDR = 8;
  localparam int SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;
  typedef struct {
    logic [7:0]  d;
    int          lat;
    logic [15:0] tms;
    int          np;
    int          kind;
    logic [7:0]  r;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  jtag_master_if #(.WIDTH(8)) ia ();
  jtag_master_if #(.WIDTH(8)) ib ();
  jtag_master #(.WIDTH(8), .DIV(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.master));
  jtag_master #(.WIDTH(8), .DIV(2)) dut_b (.clk(clk), .rst(rst), .bus(ib.master));
  int checks = 0, errors = 0, cyc = 0;
  int sa, sb, np_a, np_b, acc_a, acc_b;
  logic pa = 1'b0, pb = 1'b0;
  logic [15:0] rec_a, rec_b;
  logic [7:0] dra, drb, dr_cap_a, dr_cap_b;
  logic [3:0] ira, irb;
  exp_t qa[$], qb[$];

  function automatic int tap_nx(input int s, input logic m);
    case (s)
      TLR:     return m ? TLR : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR : PADR;
      PADR:    return m ? EX2DR : PADR;
      EX2DR:   return m ? UPDR : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR : PAIR;
      PAIR:    return m ? EX2IR : PAIR;
      EX2IR:   return m ? UPIR : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  function automatic exp_t mk(input logic [7:0] d, input int lat, input logic [15:0] t, input int np, input int kind, input logic [7:0] r);
    exp_t e;
    e.d = d; e.lat = lat; e.tms = t; e.np = np; e.kind = kind; e.r = r;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge ia.tck or posedge ia.trst)
    if (ia.trst) sa <= TLR;
    else begin
      if (sa == CAPDR) dra <= dr_cap_a;
      if (sa == SHDR) dra <= {ia.tdi, dra[7:1]};
      if (sa == CAPIR) ira <= 4'b0001;
      if (sa == SHIR) ira <= {ia.tdi, ira[3:1]};
      sa <= tap_nx(sa, ia.tms);
    end
  assign ia.tdo = sa == SHDR ? dra[0] : sa == SHIR ? ira[0] : 1'b0;

  always @(posedge ib.tck or posedge ib.trst)
    if (ib.trst) sb <= TLR;
    else begin
      if (sb == CAPDR) drb <= dr_cap_b;
      if (sb == SHDR) drb <= {ib.tdi, drb[7:1]};
      if (sb == CAPIR) irb <= 4'b0001;
      if (sb == SHIR) irb <= {ib.tdi, irb[3:1]};
      sb <= tap_nx(sb, ib.tms);
    end
  assign ib.tdo = sb == SHDR ? drb[0] : sb == SHIR ? irb[0] : 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst || (ia.cmd_valid && ia.cmd_ready)) begin
      np_a = 0; rec_a = '0; acc_a = cyc;
    end else if (ia.tck && !pa) begin
      if (np_a < 16) rec_a[np_a[3:0]] = ia.tms;
      np_a++;
    end
    pa = ia.tck;
    if (rst || (ib.cmd_valid && ib.cmd_ready)) begin
      np_b = 0; rec_b = '0; acc_b = cyc;
    end else if (ib.tck && !pb) begin
      if (np_b < 16) rec_b[np_b[3:0]] = ib.tms;
      np_b++;
    end
    pb = ib.tck;
  end

  task automatic verify(input string l, input exp_t e, input logic [7:0] d, input int np, input logic [15:0] rec,
                        input int lat, input int st, input logic [7:0] dr, input logic [3:0] ir, input logic rdy);
    check({l, "_rsp_data"}, 32'(d), 32'(e.d));
    check({l, "_latency"}, lat, e.lat);
    check({l, "_tck_periods"}, np, e.np);
    check({l, "_tms_seq"}, 32'(rec), 32'(e.tms));
    check({l, "_tap_in_rti"}, st, RTI);
    check({l, "_ready_at_rsp"}, 32'(rdy), 1);
    if (e.kind != 0) check({l, "_tap_reg"}, e.kind == 2 ? {24'h0, 4'h0, ir} : {24'h0, dr}, 32'(e.r));
  endtask

  always @(negedge clk) begin
    if (ia.rsp_valid === 1'b1) begin
      if (qa.size() == 0) check("a_unexpected_rsp", 1, 0);
      else verify("a", qa.pop_front(), ia.rsp_data, np_a, rec_a, cyc - acc_a, sa, dra, ira, ia.cmd_ready);
    end
    if (ib.rsp_valid === 1'b1) begin
      if (qb.size() == 0) check("b_unexpected_rsp", 1, 0);
      else verify("b", qb.pop_front(), ib.rsp_data, np_b, rec_b, cyc - acc_b, sb, drb, irb, ib.cmd_ready);
    end
  end

  task automatic issue_a(input logic r, input logic ir, input logic [3:0] len, input logic [7:0] d, input exp_t e);
    int n = 0;
    while (!ia.cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("a_ready_before_issue", 32'(ia.cmd_ready), 1);
    ia.cmd_rst = r; ia.cmd_ir = ir; ia.cmd_len = len; ia.cmd_data = d; ia.cmd_valid = 1'b1;
    qa.push_back(e);
    @(negedge clk);
    ia.cmd_valid = 1'b0; ia.cmd_rst = 1'b0; ia.cmd_ir = ~ir; ia.cmd_len = 4'd1; ia.cmd_data = ~d;
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (qa.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("a_rsp_arrived", qa.size(), 0);
  endtask

  task automatic wait_np_a(input int k);
    int n = 0;
    while (np_a != k && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("a_reached_period", np_a, k);
  endtask

  initial begin
    int n, na, nb;
    ia.cmd_valid = 0; ia.cmd_rst = 0; ia.cmd_ir = 0; ia.cmd_len = '0; ia.cmd_data = '0;
    ib.cmd_valid = 0; ib.cmd_rst = 0; ib.cmd_ir = 0; ib.cmd_len = '0; ib.cmd_data = '0;
    dr_cap_a = 8'h7A; dr_cap_b = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tck", 32'(ia.tck), 0);
    check("rst_tms", 32'(ia.tms), 1);
    check("rst_tdi", 32'(ia.tdi), 0);
    check("rst_trst", 32'(ia.trst), 1);
    check("rst_cmd_ready", 32'(ia.cmd_ready), 0);
    check("rst_rsp_valid", 32'(ia.rsp_valid), 0);
    check("rst_rsp_data", 32'(ia.rsp_data), 0);
    check("rst_b_trst", 32'(ib.trst), 1);
    rst = 1'b0;
    n = 0; na = 0; nb = 0;
    while ((!ia.cmd_ready || !ib.cmd_ready) && n < 100) begin
      @(negedge clk);
      n++;
      if (ia.cmd_ready && na == 0) na = n;
      if (ib.cmd_ready && nb == 0) nb = n;
    end
    check("a_post_rst_ready_cycles", na, 12);
    check("b_post_rst_ready_cycles", nb, 24);
    check("a_trst_released", 32'(ia.trst), 0);
    check("a_post_rst_periods", np_a, 6);
    check("a_post_rst_tms", 32'(rec_a), 32'h1F);
    check("a_post_rst_tap_rti", sa, RTI);
    check("b_post_rst_periods", np_b, 6);
    check("b_post_rst_tms", 32'(rec_b), 32'h1F);
    issue_a(1'b0, 1'b0, 4'd8, 8'hD4, mk(8'h7A, 26, 16'h0C01, 13, 1, 8'hD4));
    wait_done_a();
    ib.cmd_ir = 1'b1; ib.cmd_len = 4'd4; ib.cmd_data = 8'h0A; ib.cmd_valid = 1'b1;
    qb.push_back(mk(8'h01, 40, 16'h0183, 10, 2, 8'h0A));
    @(negedge clk);
    ib.cmd_valid = 1'b0; ib.cmd_data = 8'hFF; ib.cmd_ir = 1'b0;
    n = 0;
    while (qb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("b_rsp_arrived", qb.size(), 0);
    dr_cap_a = 8'h5C;
    issue_a(1'b0, 1'b0, 4'd0, 8'hFF, mk(8'h5C, 26, 16'h0C01, 13, 1, 8'hFF));
    wait_done_a();
    dr_cap_a = 8'h5E;
    issue_a(1'b0, 1'b0, 4'd3, 8'h05, mk(8'h06, 16, 16'h0061, 8, 1, 8'hAB));
    wait_np_a(4);
    ia.cmd_valid = 1'b1; ia.cmd_len = 4'd2; ia.cmd_data = 8'h03; ia.cmd_ir = 1'b0; ia.cmd_rst = 1'b0;
    check("a_busy_ready_low", 32'(ia.cmd_ready), 0);
    qa.push_back(mk(8'h02, 14, 16'h0031, 7, 1, 8'hD7));
    n = 0;
    while (!ia.cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    ia.cmd_valid = 1'b0;
    check("a_second_accepted", 32'(ia.cmd_ready), 0);
    wait_done_a();
    issue_a(1'b1, 1'b0, 4'd0, 8'h00, mk(8'h00, 12, 16'h001F, 6, 0, 8'h00));
    wait_done_a();
    dr_cap_a = 8'h3C;
    issue_a(1'b0, 1'b0, 4'd8, 8'h96, mk(8'h00, 0, 16'h0000, 0, 0, 8'h00));
    wait_np_a(6);
    rst = 1'b1;
    qa.delete();
    @(negedge clk);
    check("midrst_tck", 32'(ia.tck), 0);
    check("midrst_tms", 32'(ia.tms), 1);
    check("midrst_trst", 32'(ia.trst), 1);
    check("midrst_cmd_ready", 32'(ia.cmd_ready), 0);
    check("midrst_rsp_data", 32'(ia.rsp_data), 0);
    rst = 1'b0;
    n = 0;
    while (!ia.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("a_rerst_ready_cycles", n, 12);
    check("a_rerst_tms", 32'(rec_a), 32'h1F);
    check("a_rerst_tap_rti", sa, RTI);
    dr_cap_a = 8'hC3;
    issue_a(1'b0, 1'b0, 4'd5, 8'h0B, mk(8'h03, 20, 16'h0181, 10, 1, 8'h5E));
    wait_done_a();
    repeat (4) @(negedge clk);
    check("b_no_pending", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
